// File: rtl/img_rx_pack_wr.sv
// ============================================================================
// Module  : img_rx_pack_wr
// Brief   : UART byte stream to frame-buffer writer. It hunts an optional
//           2-byte sync header, packs bytes into pixels and writes them in order.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module img_rx_pack_wr #(
  parameter int         PIX_BYTES   = 2,
  parameter int         IMG_W       = 256,
  parameter int         IMG_H       = 256,
  parameter int         ADDR_W      = 16,
  parameter int         SYNC_EN     = 1,
  parameter logic [7:0] SYNC_B0     = 8'hA5,
  parameter logic [7:0] SYNC_B1     = 8'h5A,
  parameter int         MSB_FIRST   = 1,
  parameter int         TIMEOUT_CYC = 5000000
) (
  input  logic                   Clk,
  input  logic                   Reset_n,
  input  logic [7:0]             rx_data,
  input  logic                   Rx_Done,
  output logic                   ram_wr_en,
  output logic [ADDR_W-1:0]      ram_wr_addr,
  output logic [8*PIX_BYTES-1:0] ram_wr_data,
  output logic                   frame_busy,
  output logic                   frame_done,
  output logic [7:0]             frame_cnt,
  output logic                   err_timeout
);

  localparam int c_PIX_W = 8 * PIX_BYTES;
  localparam int c_NPIX  = IMG_W * IMG_H;
  localparam int c_BC_W  = (PIX_BYTES > 1) ? $clog2(PIX_BYTES) : 1;
  localparam int c_TMR_W = (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;

  localparam logic [c_BC_W-1:0]  c_LAST_BYTE = c_BC_W'(PIX_BYTES - 1);
  localparam logic [ADDR_W-1:0]  c_LAST_PIX  = ADDR_W'(c_NPIX - 1);
  localparam logic [c_TMR_W-1:0] c_TMR_MAX   = c_TMR_W'(TIMEOUT_CYC);

  typedef enum logic [1:0] {
    ST_HUNT  = 2'd0,
    ST_SYNC1 = 2'd1,
    ST_RECV  = 2'd2
  } state_t;

  localparam state_t c_IDLE_ST = (SYNC_EN != 0) ? ST_HUNT : ST_RECV;

  if (PIX_BYTES < 1 || PIX_BYTES > 4) begin : g_chk_pix
    $error("img_rx_pack_wr: PIX_BYTES must be 1..4");
  end
  if ((longint'(IMG_W) * longint'(IMG_H)) > (longint'(1) << ADDR_W)) begin : g_chk_addr
    $error("img_rx_pack_wr: IMG_W*IMG_H does not fit in ADDR_W");
  end

  state_t               state_q, state_d;
  logic [c_BC_W-1:0]    byte_cnt_q, byte_cnt_d;
  logic [ADDR_W-1:0]    pix_idx_q, pix_idx_d;
  logic [c_TMR_W-1:0]   timer_q, timer_d;
  logic [c_PIX_W-1:0]   pix_q, pix_d;
  logic                 wr_en_q, wr_en_d;
  logic [ADDR_W-1:0]    wr_addr_q, wr_addr_d;
  logic [c_PIX_W-1:0]   wr_data_q, wr_data_d;
  logic                 busy_q, busy_d;
  logic                 done_q, done_d;
  logic [7:0]           fcnt_q, fcnt_d;
  logic                 err_q, err_d;
  logic [c_PIX_W-1:0]   w_packed;

  // Pixel value including the byte currently on rx_data.
  if (MSB_FIRST != 0) begin : g_msb
    assign w_packed = (pix_q << 8) | c_PIX_W'(rx_data);
  end else begin : g_lsb
    always_comb begin
      w_packed = pix_q;
      for (int i = 0; i < PIX_BYTES; i++) begin
        if (byte_cnt_q == c_BC_W'(i)) w_packed[8*i +: 8] = rx_data;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    pix_idx_d  = pix_idx_q;
    timer_d    = timer_q;
    pix_d      = pix_q;
    wr_en_d    = 1'b0;
    wr_addr_d  = wr_addr_q;
    wr_data_d  = wr_data_q;
    busy_d     = busy_q;
    done_d     = 1'b0;
    fcnt_d     = fcnt_q;
    err_d      = 1'b0;

    if (Rx_Done) begin
      // A byte always wins over a timeout reached in the same cycle.
      timer_d = '0;
      case (state_q)
        ST_HUNT: begin
          if (rx_data == SYNC_B0) state_d = ST_SYNC1;
        end
        ST_SYNC1: begin
          if (rx_data == SYNC_B1)      state_d = ST_RECV;
          else if (rx_data != SYNC_B0) state_d = ST_HUNT;
        end
        ST_RECV: begin
          busy_d = 1'b1;
          if (byte_cnt_q == c_LAST_BYTE) begin
            byte_cnt_d = '0;
            pix_d      = '0;
            wr_en_d    = 1'b1;
            wr_addr_d  = pix_idx_q;
            wr_data_d  = w_packed;
            if (pix_idx_q == c_LAST_PIX) begin
              pix_idx_d = '0;
              done_d    = 1'b1;
              fcnt_d    = fcnt_q + 8'd1;
              busy_d    = 1'b0;
              state_d   = c_IDLE_ST;
            end else begin
              pix_idx_d = pix_idx_q + ADDR_W'(1);
            end
          end else begin
            byte_cnt_d = byte_cnt_q + c_BC_W'(1);
            pix_d      = w_packed;
          end
        end
        default: state_d = c_IDLE_ST;
      endcase
    end else if (busy_q || state_q == ST_SYNC1) begin
      if (TIMEOUT_CYC > 0 && timer_q == c_TMR_MAX) begin
        err_d      = 1'b1;
        byte_cnt_d = '0;
        pix_idx_d  = '0;
        pix_d      = '0;
        busy_d     = 1'b0;
        timer_d    = '0;
        state_d    = c_IDLE_ST;
      end else if (timer_q != c_TMR_MAX) begin
        timer_d = timer_q + c_TMR_W'(1);
      end
    end else begin
      timer_d = '0;
    end
  end

  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      state_q    <= c_IDLE_ST;
      byte_cnt_q <= '0;
      pix_idx_q  <= '0;
      timer_q    <= '0;
      pix_q      <= '0;
      wr_en_q    <= 1'b0;
      wr_addr_q  <= '0;
      wr_data_q  <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      fcnt_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      pix_idx_q  <= pix_idx_d;
      timer_q    <= timer_d;
      pix_q      <= pix_d;
      wr_en_q    <= wr_en_d;
      wr_addr_q  <= wr_addr_d;
      wr_data_q  <= wr_data_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      fcnt_q     <= fcnt_d;
      err_q      <= err_d;
    end
  end

  assign ram_wr_en   = wr_en_q;
  assign ram_wr_addr = wr_addr_q;
  assign ram_wr_data = wr_data_q;
  assign frame_busy  = busy_q;
  assign frame_done  = done_q;
  assign frame_cnt   = fcnt_q;
  assign err_timeout = err_q;

endmodule

`default_nettype wire

// File: tb/tb_img_rx_pack_wr.sv
// ============================================================================
// Module  : tb_img_rx_pack_wr
// Brief   : Randomised bench for img_rx_pack_wr against a frame-parsing model.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_img_rx_pack_wr;

  localparam int c_W    = 4;
  localparam int c_H    = 2;
  localparam int c_NPIX = c_W * c_H;
  localparam int c_TO   = 100;
  localparam logic [7:0] c_SB0 = 8'hA5;
  localparam logic [7:0] c_SB1 = 8'h5A;

  typedef struct packed {
    logic [15:0] addr;
    logic [31:0] data;
    logic        fd;
    logic        prev;
  } wr_t;

  logic clk, rst_n;
  logic [7:0] rx_data, rxc_data;
  logic rx_done, rxc_done;

  logic a_wr_en, a_busy, a_done, a_err;
  logic [2:0] a_addr;
  logic [15:0] a_data;
  logic [7:0] a_cnt;
  logic b_wr_en, b_busy, b_done, b_err;
  logic [2:0] b_addr;
  logic [15:0] b_data;
  logic [7:0] b_cnt;
  logic c_wr_en, c_busy, c_done, c_err;
  logic [2:0] c_addr;
  logic [7:0] c_data;
  logic [7:0] c_cnt;

  img_rx_pack_wr #(.PIX_BYTES(2), .IMG_W(c_W), .IMG_H(c_H), .ADDR_W(3), .SYNC_EN(1),
    .SYNC_B0(c_SB0), .SYNC_B1(c_SB1), .MSB_FIRST(1), .TIMEOUT_CYC(c_TO)) dut_a (
    .Clk(clk), .Reset_n(rst_n), .rx_data(rx_data), .Rx_Done(rx_done),
    .ram_wr_en(a_wr_en), .ram_wr_addr(a_addr), .ram_wr_data(a_data),
    .frame_busy(a_busy), .frame_done(a_done), .frame_cnt(a_cnt), .err_timeout(a_err));

  img_rx_pack_wr #(.PIX_BYTES(2), .IMG_W(c_W), .IMG_H(c_H), .ADDR_W(3), .SYNC_EN(1),
    .SYNC_B0(c_SB0), .SYNC_B1(c_SB1), .MSB_FIRST(0), .TIMEOUT_CYC(c_TO)) dut_b (
    .Clk(clk), .Reset_n(rst_n), .rx_data(rx_data), .Rx_Done(rx_done),
    .ram_wr_en(b_wr_en), .ram_wr_addr(b_addr), .ram_wr_data(b_data),
    .frame_busy(b_busy), .frame_done(b_done), .frame_cnt(b_cnt), .err_timeout(b_err));

  img_rx_pack_wr #(.PIX_BYTES(1), .IMG_W(c_W), .IMG_H(c_H), .ADDR_W(3), .SYNC_EN(0),
    .SYNC_B0(c_SB0), .SYNC_B1(c_SB1), .MSB_FIRST(1), .TIMEOUT_CYC(c_TO)) dut_c (
    .Clk(clk), .Reset_n(rst_n), .rx_data(rxc_data), .Rx_Done(rxc_done),
    .ram_wr_en(c_wr_en), .ram_wr_addr(c_addr), .ram_wr_data(c_data),
    .frame_busy(c_busy), .frame_done(c_done), .frame_cnt(c_cnt), .err_timeout(c_err));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  wr_t qa[$], qb[$], qc[$];
  wr_t ea[$], eb[$], ec[$];
  logic [7:0] seg[$], segc[$];
  int erra, errb, errc, errlong, strays;
  int last_rx_cyc, err_cyc_a, err_cyc_b;
  int exp_fc_ab, exp_fc_c;
  logic prev_ab, prev_c, prev_ea, prev_eb, prev_ec;

  function automatic wr_t mk(input int a, input logic [31:0] d, input logic fd, input logic p);
    wr_t w;
    w.addr = 16'(a);
    w.data = d;
    w.fd   = fd;
    w.prev = p;
    return w;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Collects writes and pulses; prev records Rx_Done in the preceding cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (a_wr_en) qa.push_back(mk(int'(a_addr), 32'(a_data), a_done, prev_ab));
      if (b_wr_en) qb.push_back(mk(int'(b_addr), 32'(b_data), b_done, prev_ab));
      if (c_wr_en) qc.push_back(mk(int'(c_addr), 32'(c_data), c_done, prev_c));
      if ((a_done && !a_wr_en) || (b_done && !b_wr_en) || (c_done && !c_wr_en)) strays++;
      if (a_err) begin erra++; err_cyc_a = cyc; if (prev_ea) errlong++; end
      if (b_err) begin errb++; err_cyc_b = cyc; if (prev_eb) errlong++; end
      if (c_err) begin errc++; if (prev_ec) errlong++; end
      if (rx_done) last_rx_cyc = cyc;
    end
    prev_ab = rx_done;
    prev_c  = rxc_done;
    prev_ea = a_err;
    prev_eb = b_err;
    prev_ec = c_err;
  end

  task automatic send_ab(input logic [7:0] b, input int gap);
    rx_data = b;
    rx_done = 1'b1;
    seg.push_back(b);
    @(posedge clk); #1;
    rx_done = 1'b0;
    repeat (gap) begin @(posedge clk); #1; end
  endtask

  task automatic send_c(input logic [7:0] b);
    rxc_data = b;
    rxc_done = 1'b1;
    segc.push_back(b);
    @(posedge clk); #1;
    rxc_done = 1'b0;
  endtask

  task automatic send_rand_ab(input int n);
    for (int k = 0; k < n; k++) send_ab(8'($urandom), int'($urandom_range(0, 3)));
  endtask

  // Expected writes: find each adjacent SB0,SB1 pair outside a frame, then
  // pair up the following bytes into pixels until the frame fills.
  task automatic build_ab(output int frames);
    int i, n;
    logic [7:0] hi, lo;
    ea.delete(); eb.delete();
    frames = 0;
    i = 0;
    n = seg.size();
    while (i < n) begin
      if (i + 1 < n && seg[i] == c_SB0 && seg[i+1] == c_SB1) begin
        i += 2;
        for (int p = 0; p < c_NPIX; p++) begin
          if (i + 1 >= n) break;
          hi = seg[i];
          lo = seg[i+1];
          i += 2;
          ea.push_back(mk(p, {16'h0, hi, lo}, p == c_NPIX - 1, 1'b1));
          eb.push_back(mk(p, {16'h0, lo, hi}, p == c_NPIX - 1, 1'b1));
          if (p == c_NPIX - 1) frames++;
        end
      end else begin
        i++;
      end
    end
  endtask

  task automatic check_ab(input string tag, input int exp_err, input logic exp_busy);
    int frames, m;
    repeat (3) begin @(posedge clk); #1; end
    build_ab(frames);
    exp_fc_ab = (exp_fc_ab + frames) % 256;
    total++;
    assert (qa.size() === ea.size()) else begin
      bad++; $error("FAIL %s a_wr_count: got %0d expected %0d", tag, qa.size(), ea.size());
    end
    total++;
    assert (qb.size() === eb.size()) else begin
      bad++; $error("FAIL %s b_wr_count: got %0d expected %0d", tag, qb.size(), eb.size());
    end
    m = (qa.size() < ea.size()) ? qa.size() : ea.size();
    for (int k = 0; k < m; k++) begin
      total++;
      assert (qa[k] === ea[k]) else begin
        bad++; $error("FAIL %s a_wr%0d {addr,data,done,prev}: got %h expected %h", tag, k, qa[k], ea[k]);
      end
    end
    m = (qb.size() < eb.size()) ? qb.size() : eb.size();
    for (int k = 0; k < m; k++) begin
      total++;
      assert (qb[k] === eb[k]) else begin
        bad++; $error("FAIL %s b_wr%0d {addr,data,done,prev}: got %h expected %h", tag, k, qb[k], eb[k]);
      end
    end
    total++;
    assert (a_cnt === 8'(exp_fc_ab) && b_cnt === 8'(exp_fc_ab)) else begin
      bad++; $error("FAIL %s frame_cnt: got a=%0d b=%0d expected %0d", tag, a_cnt, b_cnt, exp_fc_ab);
    end
    total++;
    assert (a_busy === exp_busy && b_busy === exp_busy) else begin
      bad++; $error("FAIL %s frame_busy: got a=%b b=%b expected %b", tag, a_busy, b_busy, exp_busy);
    end
    total++;
    assert (erra === exp_err && errb === exp_err && errlong === 0 && strays === 0) else begin
      bad++; $error("FAIL %s pulses: got err a=%0d b=%0d long=%0d stray_done=%0d expected err %0d, 0, 0",
                    tag, erra, errb, errlong, strays, exp_err);
    end
    seg.delete(); qa.delete(); qb.delete();
    erra = 0; errb = 0;
  endtask

  task automatic check_c(input string tag);
    int m;
    repeat (3) begin @(posedge clk); #1; end
    ec.delete();
    for (int k = 0; k < segc.size(); k++)
      ec.push_back(mk(k % c_NPIX, 32'(segc[k]), (k % c_NPIX) == c_NPIX - 1, 1'b1));
    exp_fc_c = (exp_fc_c + segc.size() / c_NPIX) % 256;
    total++;
    assert (qc.size() === ec.size()) else begin
      bad++; $error("FAIL %s c_wr_count: got %0d expected %0d", tag, qc.size(), ec.size());
    end
    m = (qc.size() < ec.size()) ? qc.size() : ec.size();
    for (int k = 0; k < m; k++) begin
      total++;
      assert (qc[k] === ec[k]) else begin
        bad++; $error("FAIL %s c_wr%0d {addr,data,done,prev}: got %h expected %h", tag, k, qc[k], ec[k]);
      end
    end
    total++;
    assert (c_cnt === 8'(exp_fc_c) && c_busy === 1'b0 && errc === 0 && strays === 0) else begin
      bad++; $error("FAIL %s c_status: got cnt=%0d busy=%b err=%0d stray=%0d expected cnt=%0d busy=0 err=0",
                    tag, c_cnt, c_busy, errc, strays, exp_fc_c);
    end
    segc.delete(); qc.delete();
  endtask

  initial begin
    int w;
    logic [7:0] g;
    rst_n = 1'b1; rx_done = 1'b0; rx_data = 8'h00; rxc_done = 1'b0; rxc_data = 8'h00;
    erra = 0; errb = 0; errc = 0; errlong = 0; strays = 0;
    exp_fc_ab = 0; exp_fc_c = 0; last_rx_cyc = 0; err_cyc_a = 0; err_cyc_b = 0;
    #1 rst_n = 1'b0;
    #2;
    total++;
    assert ({a_wr_en, a_addr, a_data, a_busy, a_done, a_cnt, a_err,
             b_wr_en, b_addr, b_data, b_busy, b_done, b_cnt, b_err,
             c_wr_en, c_addr, c_data, c_busy, c_done, c_cnt, c_err} === '0) else begin
      bad++; $error("FAIL reset_outputs: got a_data=%h a_cnt=%0d c_data=%h expected all zero", a_data, a_cnt, c_data);
    end
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic frame with the byte ramp 00..0F, then a random frame.
    repeat ($urandom_range(0, 2)) begin
      g = 8'($urandom);
      if (g == c_SB0) g = 8'h00;
      send_ab(g, 1);
    end
    send_ab(c_SB0, 0);
    send_ab(c_SB1, 2);
    total++;
    assert (a_busy === 1'b0 && b_busy === 1'b0) else begin
      bad++; $error("FAIL busy_after_header: got a=%b b=%b expected 0", a_busy, b_busy);
    end
    send_ab(8'h00, 0);
    total++;
    assert (a_busy === 1'b1 && b_busy === 1'b1) else begin
      bad++; $error("FAIL busy_first_byte: got a=%b b=%b expected 1", a_busy, b_busy);
    end
    for (int k = 1; k < 16; k++) send_ab(8'(k), int'($urandom_range(0, 3)));
    check_ab("basic_ramp", 0, 1'b0);
    send_ab(c_SB0, 0); send_ab(c_SB1, 0);
    send_rand_ab(16);
    check_ab("basic_rand", 0, 1'b0);

    // Sync hunt through a repeated first header byte.
    send_ab(8'h11, 0); send_ab(c_SB0, 1); send_ab(c_SB0, 0); send_ab(c_SB1, 0);
    send_rand_ab(16);
    check_ab("hunt_a5a55a", 0, 1'b0);
    send_ab(c_SB0, 0); send_ab(8'h33, 0); send_ab(c_SB1, 0);
    send_rand_ab(5);
    check_ab("hunt_broken", 0, 1'b0);
    send_ab(c_SB0, 0); send_ab(c_SB1, 1);
    send_rand_ab(16);
    check_ab("hunt_after_broken", 0, 1'b0);

    // Timeout after a partial frame.
    send_ab(c_SB0, 0); send_ab(c_SB1, 0);
    send_rand_ab(5);
    w = 0;
    while (!(erra > 0 && errb > 0) && w < 300) begin @(posedge clk); #1; w++; end
    total++;
    assert (w < 300) else begin
      bad++; $error("FAIL timeout_wait: got no err_timeout within %0d cycles expected a pulse", w);
    end
    total++;
    assert (err_cyc_a - last_rx_cyc >= c_TO && err_cyc_a - last_rx_cyc <= c_TO + 2 &&
            err_cyc_b == err_cyc_a) else begin
      bad++; $error("FAIL timeout_delay: got a=%0d b=%0d cycles after last byte expected %0d..%0d",
                    err_cyc_a - last_rx_cyc, err_cyc_b - last_rx_cyc, c_TO, c_TO + 2);
    end
    check_ab("timeout_partial", 1, 1'b0);
    send_ab(c_SB0, 0); send_ab(c_SB1, 0);
    send_rand_ab(16);
    check_ab("after_timeout", 0, 1'b0);

    // Asynchronous reset in the middle of a frame.
    send_ab(c_SB0, 0); send_ab(c_SB1, 0);
    send_rand_ab(3);
    check_ab("pre_reset", 0, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    total++;
    assert ({a_wr_en, a_addr, a_data, a_busy, a_done, a_cnt, a_err,
             b_wr_en, b_addr, b_data, b_busy, b_done, b_cnt, b_err} === '0) else begin
      bad++; $error("FAIL midframe_reset: got a_busy=%b a_data=%h a_cnt=%0d expected all zero", a_busy, a_data, a_cnt);
    end
    exp_fc_ab = 0; exp_fc_c = 0;
    @(posedge clk); #1 rst_n = 1'b1;
    @(posedge clk); #1;
    send_ab(c_SB0, 0); send_ab(c_SB1, 0);
    send_rand_ab(16);
    check_ab("after_reset", 0, 1'b0);

    // Free-running single-byte pixels, back-to-back bytes.
    for (int k = 0; k < c_NPIX; k++) send_c(8'($urandom));
    check_c("free_frame1");
    for (int k = 0; k < c_NPIX; k++) send_c(8'($urandom));
    check_c("free_frame2");
    for (int k = 0; k < 254 * c_NPIX; k++) send_c(8'($urandom));
    check_c("free_wrap");
    total++;
    assert (c_cnt === 8'd0) else begin
      bad++; $error("FAIL frame_cnt_wrap: got %0d expected 0", c_cnt);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/img_rx_pack_wr.md
Name: img_rx_pack_wr

Overview:
- Parametrised UART-to-frame-buffer writer.
- Takes bytes from uart_byte_rx (rx_data/Rx_Done) and optionally hunts a 2-byte frame sync header.
- Packs PIX_BYTES bytes per pixel in a selectable byte order, then issues one RAM write per pixel at sequential addresses until IMG_W*IMG_H pixels are written.
- Adds an inter-byte timeout that resynchronises after a broken transfer, plus frame status outputs for the display side.

Parameters:
PIX_BYTES, 2, bytes per pixel (1..4); pixel width = 8*PIX_BYTES
IMG_W, 256, image width in pixels
IMG_H, 256, image height in pixels
ADDR_W, 16, RAM address width; IMG_W*IMG_H <= 2**ADDR_W (elaboration check)
SYNC_EN, 1, 1 = require header SYNC_B0,SYNC_B1 before each frame; 0 = free-running
SYNC_B0, 8'hA5, first header byte
SYNC_B1, 8'h5A, second header byte
MSB_FIRST, 1, 1 = first received byte is pixel MSB; 0 = first byte is LSB
TIMEOUT_CYC, 5000000, idle cycles mid-frame before abort; 0 disables the timeout

Ports:
Clk  in  1  system clock; the block's only clock
Reset_n  in  1  asynchronous, active-low reset
rx_data  in  8  received byte; valid when Rx_Done=1
Rx_Done  in  1  byte strobe; every cycle it is high counts as one byte
ram_wr_en  out  1  one-cycle RAM write strobe
ram_wr_addr  out  ADDR_W  pixel address, 0..IMG_W*IMG_H-1
ram_wr_data  out  8*PIX_BYTES  packed pixel
frame_busy  out  1  a frame is being received
frame_done  out  1  one-cycle pulse on the last pixel write of a frame
frame_cnt  out  8  completed frames, wraps 255->0
err_timeout  out  1  one-cycle pulse when a transfer is aborted

Behaviour:
- Reset (asynchronous, any time including mid-frame):
  - all outputs 0.
  - byte_cnt=0, pix_idx=0, timer=0, pixel shift register=0.
  - state = HUNT if SYNC_EN=1, else RECV.
- States:
  - HUNT: byte == SYNC_B0 -> SYNC1; any other byte stays in HUNT.
  - SYNC1: byte == SYNC_B1 -> RECV; byte == SYNC_B0 stays in SYNC1; any other byte -> HUNT.
  - RECV: header bytes are ordinary data bytes here; no sync matching.
- Packing in RECV:
  - Each byte increments byte_cnt.
  - MSB_FIRST=1: register shifts left by 8 and the new byte enters bits [7:0].
  - MSB_FIRST=0: byte is written to lane byte_cnt, i.e. bits [8*byte_cnt+7 : 8*byte_cnt].
  - On byte PIX_BYTES-1, byte_cnt returns to 0 and a write fires.
- Write timing:
  - ram_wr_en is registered: high exactly one cycle, the cycle after the Rx_Done that completed the pixel.
  - In that cycle ram_wr_addr = pix_idx and ram_wr_data = packed pixel.
  - pix_idx then increments.
  - ram_wr_addr and ram_wr_data hold their last values while ram_wr_en=0.
- Frame end:
  - The write at pix_idx = IMG_W*IMG_H-1 asserts frame_done in the same cycle as ram_wr_en.
  - frame_cnt increments and wraps 255->0.
  - pix_idx wraps to 0.
  - state -> HUNT if SYNC_EN=1, else stays in RECV.
- frame_busy:
  - Set on the first data byte accepted in RECV.
  - Cleared in the cycle frame_done asserts, or on a timeout abort.
  - Bytes arriving in HUNT/SYNC1 never cause writes.
- Timeout (TIMEOUT_CYC>0):
  - timer counts cycles without Rx_Done while frame_busy=1, or while state=SYNC1.
  - It clears on every Rx_Done.
  - When timer reaches TIMEOUT_CYC:
    - err_timeout pulses for one cycle.
    - The partial pixel is discarded and byte_cnt=0, pix_idx=0, frame_busy=0.
    - state -> HUNT if SYNC_EN=1, else RECV.
    - frame_cnt is unchanged and no write is issued.
  - If Rx_Done arrives in the same cycle the limit is reached, the byte wins: it is processed and timer clears.
  - Timer width is $clog2(TIMEOUT_CYC+1); it saturates and never wraps.
- Back-to-back Rx_Done on consecutive cycles is supported, one byte per cycle. With PIX_BYTES=1 this gives one write per cycle.
- Rx_Done in the same cycle as a pending ram_wr_en:
  - Both take effect.
  - The write uses the previously latched pixel.
  - The new byte starts the next pixel.

Test Plan:
All scenarios use IMG_W=4, IMG_H=2, PIX_BYTES=2, TIMEOUT_CYC=100 unless stated.
- Basic frame, SYNC_EN=1, MSB_FIRST=1: send A5 5A then bytes 00..0F.
  - Expect 8 writes: addr 0..7, data 16'h0001, 16'h0203, … 16'h0E0F.
  - frame_done coincides with the addr-7 write; frame_cnt=1; return to HUNT.
- Byte order, MSB_FIRST=0: same stream -> data 16'h0100, 16'h0302, … 16'h0F0E.
- Sync hunt: send 11 A5 A5 5A then data.
  - No writes before 5A.
  - First write is addr 0 carrying the first two bytes after 5A.
  - Sending A5 33 5A stays in HUNT with no writes.
- Timeout mid-frame:
  - Send header, 5 data bytes, then idle for 100 cycles.
  - Expect err_timeout for one cycle, 2 writes only, frame_cnt unchanged.
  - A new header plus 16 bytes then writes from addr 0 again.
- Free-running, SYNC_EN=0, PIX_BYTES=1, back-to-back Rx_Done:
  - 8 bytes -> 8 consecutive-cycle writes, frame_done, then the next 8 bytes rewrite addr 0..7 and frame_cnt=2.
  - Separately, 256 frames -> frame_cnt wraps to 0.
- Reset mid-frame: assert Reset_n=0 after 3 data bytes.
  - Outputs clear immediately (asynchronous).
  - After release, a full header plus frame writes from addr 0 with correct data.
